// File: rtl/mips_regfile.sv
// 32x32 MIPS architectural register file: two combinational read ports, one synchronous write port.
// Define MIPS_REGFILE_BYPASS_EN to forward a same-cycle write (wd3) onto matching read ports.
module mips_regfile #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] ra1,
  input  logic [DEPTH_LOG2-1:0] ra2,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  input  logic                  we3,
  input  logic [DEPTH_LOG2-1:0] wa3,
  input  logic [WIDTH-1:0]      wd3
);

  localparam int NREGS = 2 ** DEPTH_LOG2;

  // r0 has no storage; the array starts at index 1.
  logic [WIDTH-1:0] regs [1:NREGS-1];

  logic write_ok;

  assign write_ok = we3 && (wa3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = regs[ra1];
`ifdef MIPS_REGFILE_BYPASS_EN
      // Forwarding is suppressed under reset so the ports still read zero.
      if (rst_n && write_ok && (wa3 == ra1)) begin
        rd1 = wd3;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = regs[ra2];
`ifdef MIPS_REGFILE_BYPASS_EN
      if (rst_n && write_ok && (wa3 == ra2)) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: scoreboard queue of expected read-port values,
// a bench-side register model, and a tiny ALU model for the datapath hookup scenario.
module tb_mips_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model [0:31];
  int          checks = 0;
  int          errors = 0;

  mips_regfile #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we3   (we3),
    .wa3   (wa3),
    .wd3   (wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] cont);
    case (cont)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Single committed write: drive at negedge, commit on the next posedge, release we3.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = addr;
    wd3 = data;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic test_reset();
    ra1 = 5'd5;
    ra2 = 5'd31;
    we3 = 1'b1;
    wa3 = 5'd5;
    wd3 = 32'h5555_5555;
    sb.push_back('{"reset_held", 5'd5, 32'h0, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end

    // Edges pass with a write pending; reset must block it and bypass must not leak.
    ra2 = 5'd5;
    sb.push_back('{"reset_write_ignored", 5'd5, 32'h0, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end

    @(negedge clk);
    we3   = 1'b0;
    rst_n = 1'b1;
    model_clear();
    sb.push_back('{"after_release_r5", 5'd5, 32'h0, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end

    // Async clear between edges.
    do_write(5'd5, 32'hDEAD_BEEF);
    sb.push_back('{"r5_written", 5'd5, model[5], model[5]});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    sb.push_back('{"async_clear_r5", 5'd5, 32'h0, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write();
    do_write(5'd7, 32'h1234_5678);
    do_write(5'd31, 32'hCAFE_F00D);
    ra1 = 5'd7;
    ra2 = 5'd31;
    sb.push_back('{"basic_r7_r31", 5'd7, model[7], model[31]});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end
    if (model[7] !== 32'h1234_5678 || model[31] !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL basic_model: got %h/%h expected 12345678/cafef00d", model[7], model[31]);
    end
  endtask

  task automatic test_r0();
    for (int i = 1; i < 32; i++) do_write(i[4:0], 32'h0101_0101 * i ^ 32'hA5A5_0000);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd0;
    wd3 = 32'hFFFF_FFFF;
    ra1 = 5'd0;
    ra2 = 5'd0;
    sb.push_back('{"r0_pre_edge", 5'd0, 32'h0, 32'h0});
    sb.push_back('{"r0_post_edge", 5'd0, 32'h0, 32'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end
    @(posedge clk);
    #1;
    we3 = 1'b0;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end

    for (int i = 1; i < 32; i++) sb.push_back('{"r0_others_intact", i[4:0], model[i], model[i]});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra1 = e.addr;
      ra2 = e.addr;
      #1;
      checks++;
      if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s r%0d rd1: got %h expected %h", e.name, e.addr, rd1, e.e1); end
      checks++;
      if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s r%0d rd2: got %h expected %h", e.name, e.addr, rd2, e.e2); end
    end
  endtask

  task automatic test_write_disable();
    do_write(5'd9, 32'h0000_0001);
    @(negedge clk);
    we3 = 1'b0;
    wa3 = 5'd9;
    wd3 = 32'hAAAA_AAAA;
    ra1 = 5'd9;
    ra2 = 5'd9;
    for (int k = 0; k < 3; k++) sb.push_back('{"write_disable_r9", 5'd9, 32'h0000_0001, 32'h0000_0001});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s edge%0d: got %h expected %h", e.name, k, rd1, e.e1); end
    end
  endtask

  task automatic test_same_cycle_raw();
    logic [31:0] exp_pre;
`ifdef MIPS_REGFILE_BYPASS_EN
    exp_pre = 32'h2222_2222;
`else
    exp_pre = 32'h1111_1111;
`endif
    do_write(5'd3, 32'h1111_1111);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd3;
    wd3 = 32'h2222_2222;
    ra1 = 5'd3;
    ra2 = 5'd4;
    sb.push_back('{"raw_pre_edge", 5'd3, exp_pre, model[4]});
    sb.push_back('{"raw_post_edge", 5'd3, 32'h2222_2222, model[4]});
    #1;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
    checks++;
    if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s rd2: got %h expected %h", e.name, rd2, e.e2); end
    @(posedge clk);
    #1;
    we3 = 1'b0;
    model[3] = 32'h2222_2222;
    e = sb.pop_front();
    checks++;
    if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s rd1: got %h expected %h", e.name, rd1, e.e1); end
  endtask

  task automatic test_alu_hookup();
    logic [31:0] res;
    do_write(5'd1, 32'd5);
    do_write(5'd2, 32'd3);
    ra1 = 5'd1;
    ra2 = 5'd2;
    sb.push_back('{"alu_sub", 5'd1, 32'd2, 32'd0});
    #1;
    res = alu(rd1, rd2, 4'b0110);
    e = sb.pop_front();
    checks++;
    if (res !== e.e1) begin errors++; $display("[TB] FAIL %s res: got %h expected %h", e.name, res, e.e1); end

    do_write(5'd1, 32'd3);
    do_write(5'd2, 32'd5);
    sb.push_back('{"alu_slt", 5'd1, 32'd1, 32'd0});
    #1;
    res = alu(rd1, rd2, 4'b0111);
    e = sb.pop_front();
    checks++;
    if (res !== e.e1) begin errors++; $display("[TB] FAIL %s res: got %h expected %h", e.name, res, e.e1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data = $urandom;
      we3 = 1'b1;
      wa3 = 5'(10 + i);
      wd3 = data;
      model[10 + i] = data;
      sb.push_back('{"back_to_back", 5'(10 + i), data, data});
      @(negedge clk);
    end
    we3 = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra1 = e.addr;
      ra2 = e.addr;
      #1;
      checks++;
      if (rd1 !== e.e1) begin errors++; $display("[TB] FAIL %s r%0d rd1: got %h expected %h", e.name, e.addr, rd1, e.e1); end
      checks++;
      if (rd2 !== e.e2) begin errors++; $display("[TB] FAIL %s r%0d rd2: got %h expected %h", e.name, e.addr, rd2, e.e2); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we3   = 1'b0;
    wa3   = 5'd0;
    wd3   = 32'h0;
    ra1   = 5'd0;
    ra2   = 5'd0;
    model_clear();
    test_reset();
    test_basic_write();
    test_r0();
    test_write_disable();
    test_same_cycle_raw();
    test_alu_hookup();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
